// File: rtl/rotate_feed_stage.sv
// Purpose: queues rotate requests in a DEPTH-entry FIFO and feeds the head entry to an external right-rotator.
// Latency: a request taken into an empty FIFO shows up on out_data one edge after it is accepted.
// Backpressure: a stalled output freezes the FIFO head; in_ready drops once count reaches DEPTH.
module rotate_feed_stage #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_data,
    input  logic [2:0]               in_amt,
    input  logic                     in_dir,
    output logic [7:0]               rot_data,
    output logic [2:0]               rot_amt,
    input  logic [7:0]               rot_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    // Each entry holds {dir, amt, data}.
    logic [11:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [11:0]   head;

    assign fifo_empty = (count == '0);
    // in_ready looks only at the registered count, so a pop in the same cycle does not reopen a full FIFO.
    assign in_ready   = (count < FULL_CNT);
    assign push       = in_valid && in_ready;
    assign pop        = !fifo_empty && (!out_valid || out_ready);
    assign head       = mem[rd_ptr];

    // Drive the head entry to the rotator; a left rotate by n is a right rotate by (8 - n) mod 8.
    always_comb begin
        rot_data = 8'h00;
        rot_amt  = 3'd0;
        if (!fifo_empty) begin
            rot_data = head[7:0];
            rot_amt  = head[11] ? (3'd0 - head[10:8]) : head[10:8];
        end
    end

    // Storage array is not reset: stale entries are unreachable once the pointers and count clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_dir, in_amt, in_data};
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy tracks push minus pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
        end
    end

    // Output register captures the rotator result on pop, otherwise empties when the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= rot_result;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rotate_feed_stage.sv
module tb_rotate_feed_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic       in_dir;
    logic [7:0] rot_data;
    logic [2:0] rot_amt;
    logic [7:0] rot_result;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] count;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic rnd_on;

    rotate_feed_stage #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .in_dir(in_dir),
        .rot_data(rot_data), .rot_amt(rot_amt), .rot_result(rot_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rotr(input logic [7:0] d, input logic [2:0] a);
        logic [15:0] t;
        t = {d, d} >> a;
        return t[7:0];
    endfunction

    // Behavioural stand-in for the external combinational rotator.
    assign rot_result = rotr(rot_data, rot_amt);

    function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] a, input logic dr);
        int eff;
        eff = dr ? ((8 - int'(a)) % 8) : int'(a);
        return rotr(d, 3'(eff));
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: every consumed output must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("stray_out", {31'b0, out_valid}, 32'd0);
            end else begin
                check("out_seq", {24'b0, out_data}, {24'b0, exp_q.pop_front()});
            end
        end
    end

    // Offer one request and hold it until accepted; the expected result is queued at acceptance.
    task automatic push(input logic [7:0] d, input logic [2:0] a, input logic dr, input logic [7:0] e);
        int n;
        n = 0;
        in_data = d; in_amt = a; in_dir = dr; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("push_timeout", 32'd0, 32'd1);
        else exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] d;
        logic [2:0] a;
        logic       dr;

        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_amt = 3'd0; in_dir = 1'b0;
        out_ready = 1'b1; rnd_on = 1'b0;
        #12;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", {24'b0, out_data}, 32'd0);
        check("rst_count", {29'b0, count}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_rot_data", {24'b0, rot_data}, 32'd0);
        check("rst_rot_amt", {29'b0, rot_amt}, 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single right rotate, then two left conversions.
        push(8'hB4, 3'd3, 1'b0, 8'h96);
        check("r3_rot_amt", {29'b0, rot_amt}, 32'd3);
        check("r3_count_q", {29'b0, count}, 32'd1);
        @(posedge clk); #1;
        check("r3_latency_vld", {31'b0, out_valid}, 32'd1);
        check("r3_out_data", {24'b0, out_data}, 32'h96);
        check("r3_count_0", {29'b0, count}, 32'd0);
        drain();

        push(8'h81, 3'd1, 1'b1, 8'h03);
        check("l1_rot_amt", {29'b0, rot_amt}, 32'd7);
        @(posedge clk); #1;
        check("l1_out_data", {24'b0, out_data}, 32'h03);
        drain();

        push(8'h5A, 3'd0, 1'b1, 8'h5A);
        check("l0_rot_amt", {29'b0, rot_amt}, 32'd0);
        @(posedge clk); #1;
        check("l0_out_data", {24'b0, out_data}, 32'h5A);
        drain();

        // Back-pressure: five fit (one in output register, four in FIFO), sixth waits.
        out_ready = 1'b0;
        push(8'h01, 3'd1, 1'b0, 8'h80);
        push(8'h0F, 3'd4, 1'b0, 8'hF0);
        push(8'hC3, 3'd2, 1'b1, 8'h0F);
        push(8'h12, 3'd4, 1'b1, 8'h21);
        push(8'hA5, 3'd1, 1'b0, 8'hD2);
        check("bp_count_full", {29'b0, count}, 32'd4);
        check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        check("bp_first_held", {24'b0, out_data}, 32'h80);
        in_data = 8'h3C; in_amt = 3'd2; in_dir = 1'b0; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("bp_sixth_refused", {29'b0, count}, 32'd4);
        check("bp_out_frozen", {24'b0, out_data}, 32'h80);
        out_ready = 1'b1;
        push(8'h3C, 3'd2, 1'b0, 8'h0F);
        drain();

        // Simultaneous push and pop with two entries queued.
        out_ready = 1'b0;
        push(8'hF0, 3'd4, 1'b0, 8'h0F);
        push(8'h80, 3'd7, 1'b0, 8'h01);
        push(8'h55, 3'd1, 1'b1, 8'hAA);
        check("pp_count_before", {29'b0, count}, 32'd2);
        check("pp_vld_before", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
        push(8'h33, 3'd2, 1'b0, 8'hCC);
        check("pp_count_same", {29'b0, count}, 32'd2);
        check("pp_next_captured", {24'b0, out_data}, 32'h01);
        drain();

        // Pointer wrap under random consumer stalls.
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    d = 8'($urandom); a = 3'($urandom); dr = 1'($urandom);
                    push(d, a, dr, model(d, a, dr));
                end
                rnd_on = 1'b0;
            end
        join
        out_ready = 1'b1;
        drain();

        // Mid-stream reset with three queued and one held in the output register.
        out_ready = 1'b0;
        push(8'h11, 3'd1, 1'b0, 8'h88);
        push(8'h22, 3'd1, 1'b0, 8'h11);
        push(8'h44, 3'd1, 1'b0, 8'h22);
        push(8'h66, 3'd1, 1'b0, 8'h33);
        check("mr_count_pre", {29'b0, count}, 32'd3);
        check("mr_vld_pre", {31'b0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_out_valid", {31'b0, out_valid}, 32'd0);
        check("mr_out_data", {24'b0, out_data}, 32'd0);
        check("mr_count", {29'b0, count}, 32'd0);
        check("mr_in_ready", {31'b0, in_ready}, 32'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("mr_no_stale_vld", {31'b0, out_valid}, 32'd0);
        check("mr_count_after", {29'b0, count}, 32'd0);

        // Queue still works after reset.
        push(8'hB4, 3'd3, 1'b1, 8'hA5);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
